// File: rtl/pkt_ctrl_demux_if.sv
// AXI-Stream bundle used by pkt_ctrl_demux for its input and both outputs.
// The master drives the payload and tvalid; the slave drives tready.
interface pkt_ctrl_demux_if #(
  parameter int DATA_WIDTH = 512
);
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tuser_err;
  logic                    tvalid;
  logic                    tlast;
  logic                    tready;

  modport master (output tdata, tkeep, tuser_err, tvalid, tlast, input tready);
  modport slave  (input tdata, tkeep, tuser_err, tvalid, tlast, output tready);
endinterface

// File: rtl/pkt_ctrl_demux.sv
// Classifies each H2C packet on its first beat and routes the whole packet to
// the data pipeline, the control port, or drops it. Also keeps per-class counters.
module pkt_ctrl_demux #(
  parameter int          C_DATA_WIDTH    = 512,
  parameter logic [15:0] C_CTRL_UDP_PORT = 16'hF1F2
) (
  input  logic               axis_aclk,
  input  logic               axis_rst,
  pkt_ctrl_demux_if.slave    s_axis,
  pkt_ctrl_demux_if.master   m_axis_data,
  pkt_ctrl_demux_if.master   m_axis_ctrl,
  output logic [31:0]        cnt_data_pkts,
  output logic [31:0]        cnt_ctrl_pkts,
  output logic [31:0]        cnt_drop_pkts
);
  localparam int KW = C_DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, FWD_DATA, FWD_CTRL, DROP} state_t;

  state_t                  state;
  state_t                  first_cls;
  state_t                  pkt_cls;

  logic [15:0]             tpid;
  logic [15:0]             ether_type;
  logic [7:0]              ip_proto;
  logic [15:0]             udp_dport;
  logic                    is_ctrl;

  logic                    data_vld;
  logic [C_DATA_WIDTH-1:0] data_dat;
  logic [KW-1:0]           data_kp;
  logic                    data_lst;
  logic                    ctrl_vld;
  logic [C_DATA_WIDTH-1:0] ctrl_dat;
  logic [KW-1:0]           ctrl_kp;
  logic                    ctrl_lst;

  logic                    data_can;
  logic                    ctrl_can;
  logic                    ready;
  logic                    hs;
  logic                    to_data;
  logic                    to_ctrl;

  // Network byte order: the lower byte index is the field's MSB.
  assign tpid       = {s_axis.tdata[12*8 +: 8], s_axis.tdata[13*8 +: 8]};
  assign ether_type = {s_axis.tdata[16*8 +: 8], s_axis.tdata[17*8 +: 8]};
  assign ip_proto   =  s_axis.tdata[27*8 +: 8];
  assign udp_dport  = {s_axis.tdata[40*8 +: 8], s_axis.tdata[41*8 +: 8]};

  assign is_ctrl = (tpid == 16'h8100) && (ether_type == 16'h0800) &&
                   (ip_proto == 8'h11) && (udp_dport == C_CTRL_UDP_PORT);

  assign first_cls = s_axis.tuser_err ? DROP : (is_ctrl ? FWD_CTRL : FWD_DATA);
  assign pkt_cls   = (state == IDLE) ? first_cls : state;

  assign data_can = !data_vld || m_axis_data.tready;
  assign ctrl_can = !ctrl_vld || m_axis_ctrl.tready;

  // IDLE waits on both registers so a first beat never needs to know its class
  // before it is accepted.
  always_comb begin
    // NOTE: assigning a default first keeps every path driven, so no latch is inferred.
    ready = 1'b0;
    if (!axis_rst) begin
      unique case (state)
        IDLE:     ready = data_can && ctrl_can;
        FWD_DATA: ready = data_can;
        FWD_CTRL: ready = ctrl_can;
        DROP:     ready = 1'b1;
        default:  ready = 1'b0;
      endcase
    end
  end

  assign s_axis.tready = ready;
  assign hs            = s_axis.tvalid && ready;
  assign to_data       = hs && (pkt_cls == FWD_DATA);
  assign to_ctrl       = hs && (pkt_cls == FWD_CTRL);

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      state         <= IDLE;
      data_vld      <= 1'b0;
      data_dat      <= '0;
      data_kp       <= '0;
      data_lst      <= 1'b0;
      ctrl_vld      <= 1'b0;
      ctrl_dat      <= '0;
      ctrl_kp       <= '0;
      ctrl_lst      <= 1'b0;
      cnt_data_pkts <= '0;
      cnt_ctrl_pkts <= '0;
      cnt_drop_pkts <= '0;
    end else begin
      // NOTE: non-blocking assignments make every register see pre-edge values,
      // so the drain-then-reload ordering below is race-free.
      if (m_axis_data.tready) data_vld <= 1'b0;
      if (to_data) begin
        data_vld <= 1'b1;
        data_dat <= s_axis.tdata;
        data_kp  <= s_axis.tkeep;
        data_lst <= s_axis.tlast;
      end

      if (m_axis_ctrl.tready) ctrl_vld <= 1'b0;
      if (to_ctrl) begin
        ctrl_vld <= 1'b1;
        ctrl_dat <= s_axis.tdata;
        ctrl_kp  <= s_axis.tkeep;
        ctrl_lst <= s_axis.tlast;
      end

      // A single-beat packet starts and ends in IDLE within one handshake.
      if (hs) begin
        state <= s_axis.tlast ? IDLE : pkt_cls;
        if (s_axis.tlast) begin
          unique case (pkt_cls)
            FWD_DATA: cnt_data_pkts <= cnt_data_pkts + 32'd1;
            FWD_CTRL: cnt_ctrl_pkts <= cnt_ctrl_pkts + 32'd1;
            DROP:     cnt_drop_pkts <= cnt_drop_pkts + 32'd1;
            default:  ;
          endcase
        end
      end
    end
  end

  assign m_axis_data.tvalid    = data_vld;
  assign m_axis_data.tdata     = data_dat;
  assign m_axis_data.tkeep     = data_kp;
  assign m_axis_data.tlast     = data_lst;
  assign m_axis_data.tuser_err = 1'b0;

  assign m_axis_ctrl.tvalid    = ctrl_vld;
  assign m_axis_ctrl.tdata     = ctrl_dat;
  assign m_axis_ctrl.tkeep     = ctrl_kp;
  assign m_axis_ctrl.tlast     = ctrl_lst;
  assign m_axis_ctrl.tuser_err = 1'b0;
endmodule

// File: tb/tb_pkt_ctrl_demux.sv
// Self-checking bench for pkt_ctrl_demux: directed scenarios plus a random packet
// mix, scored against a packet-level reference model with per-output queues.
module tb_pkt_ctrl_demux;
  localparam int DW = 512;
  localparam int KW = DW / 8;
  localparam int BUDGET = 2000;

  typedef struct packed {
    logic          last;
    logic [KW-1:0] keep;
    logic [DW-1:0] data;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cnt_d;
  logic [31:0] cnt_c;
  logic [31:0] cnt_x;

  always #5 clk = ~clk;

  pkt_ctrl_demux_if #(.DATA_WIDTH(DW)) s_if ();
  pkt_ctrl_demux_if #(.DATA_WIDTH(DW)) d_if ();
  pkt_ctrl_demux_if #(.DATA_WIDTH(DW)) c_if ();

  pkt_ctrl_demux #(.C_DATA_WIDTH(DW), .C_CTRL_UDP_PORT(16'hF1F2)) dut (
    .axis_aclk     (clk),
    .axis_rst      (rst),
    .s_axis        (s_if),
    .m_axis_data   (d_if),
    .m_axis_ctrl   (c_if),
    .cnt_data_pkts (cnt_d),
    .cnt_ctrl_pkts (cnt_c),
    .cnt_drop_pkts (cnt_x)
  );

  // Reference model state: expected beats per output, expected counters
  // (index 0 data, 1 ctrl, 2 drop) and the class of the packet in flight.
  beat_t       exp_d[$];
  beat_t       exp_c[$];
  int unsigned exp_cnt [3];
  int          cur_cls;
  bit          rand_rdy;
  longint      cyc = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[32*i +: 32] = $urandom;
    return d;
  endfunction

  function automatic logic [KW-1:0] rand_keep();
    logic [KW-1:0] k;
    k = {$urandom, $urandom};
    if (k == '0) k = 1;
    return k;
  endfunction

  function automatic logic [DW-1:0] mk_hdr(input logic [15:0] tpid, input logic [15:0] ety,
                                           input logic [7:0] proto, input logic [15:0] port);
    logic [DW-1:0] d;
    d = rand_data();
    d[12*8 +: 8] = tpid[15:8];
    d[13*8 +: 8] = tpid[7:0];
    d[16*8 +: 8] = ety[15:8];
    d[17*8 +: 8] = ety[7:0];
    d[27*8 +: 8] = proto;
    d[40*8 +: 8] = port[15:8];
    d[41*8 +: 8] = port[7:0];
    return d;
  endfunction

  function automatic int byte_at(input logic [DW-1:0] d, input int i);
    return int'((d >> (8 * i)) & 'hFF);
  endfunction

  // Packet class from the header rules: error wins, then control match, else data.
  function automatic int ref_class(input logic [DW-1:0] d, input logic err);
    if (err) return 2;
    if (byte_at(d, 12) * 256 + byte_at(d, 13) == 'h8100 &&
        byte_at(d, 16) * 256 + byte_at(d, 17) == 'h0800 &&
        byte_at(d, 27) == 'h11 &&
        byte_at(d, 40) * 256 + byte_at(d, 41) == 'hF1F2) return 1;
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (rand_rdy) begin
      d_if.tready = ($urandom_range(0, 3) != 0);
      c_if.tready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l,
                           input logic err, input bit first);
    bit got = 0;
    s_if.tdata     = d;
    s_if.tkeep     = k;
    s_if.tlast     = l;
    s_if.tuser_err = err;
    s_if.tvalid    = 1'b1;
    for (int i = 0; i < BUDGET && !got; i++) begin
      @(negedge clk);
      if (s_if.tready === 1'b1) begin
        got = 1;
        if (first) cur_cls = ref_class(d, err);
        if (cur_cls == 0) exp_d.push_back({l, k, d});
        else if (cur_cls == 1) exp_c.push_back({l, k, d});
        if (l) exp_cnt[cur_cls]++;
      end
      step();
    end
    check("in_handshake", DW'(got), 1);
    s_if.tvalid = 1'b0;
  endtask

  task automatic send_pkt(input logic [DW-1:0] hdr, input int nb, input logic err);
    for (int b = 0; b < nb; b++)
      send_beat((b == 0) ? hdr : rand_data(), (b == nb - 1) ? rand_keep() : '1,
                b == nb - 1, (b == 0) ? err : 1'($urandom_range(0, 1)), b == 0);
  endtask

  task automatic drain();
    rand_rdy    = 0;
    d_if.tready = 1'b1;
    c_if.tready = 1'b1;
    for (int i = 0; i < BUDGET && (exp_d.size() != 0 || exp_c.size() != 0); i++) step();
    check("drain_data_left", DW'(exp_d.size()), 0);
    check("drain_ctrl_left", DW'(exp_c.size()), 0);
  endtask

  task automatic check_cnts();
    check("cnt_data", cnt_d, exp_cnt[0]);
    check("cnt_ctrl", cnt_c, exp_cnt[1]);
    check("cnt_drop", cnt_x, exp_cnt[2]);
  endtask

  // Output monitors: in-order scoring against the model queues and payload
  // stability while a valid beat is stalled.
  logic  d_stall = 1'b0;
  logic  c_stall = 1'b0;
  beat_t d_prev;
  beat_t c_prev;

  always @(negedge clk) begin
    if (rst) begin
      d_stall <= 1'b0;
    end else begin
      if (d_stall) begin
        check("data_hold_valid", DW'(d_if.tvalid), 1);
        check("data_hold_tdata", d_if.tdata, d_prev.data);
        check("data_hold_keep_last", DW'({d_if.tlast, d_if.tkeep}), DW'({d_prev.last, d_prev.keep}));
      end
      if (d_if.tvalid && d_if.tready) begin
        if (exp_d.size() == 0) check("data_extra_beat", DW'(d_if.tvalid), 0);
        else begin
          check("data_tdata", d_if.tdata, exp_d[0].data);
          check("data_keep_last", DW'({d_if.tlast, d_if.tkeep}), DW'({exp_d[0].last, exp_d[0].keep}));
          void'(exp_d.pop_front());
        end
      end
      d_stall <= d_if.tvalid && !d_if.tready;
      d_prev  <= {d_if.tlast, d_if.tkeep, d_if.tdata};
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      c_stall <= 1'b0;
    end else begin
      if (c_stall) begin
        check("ctrl_hold_valid", DW'(c_if.tvalid), 1);
        check("ctrl_hold_tdata", c_if.tdata, c_prev.data);
        check("ctrl_hold_keep_last", DW'({c_if.tlast, c_if.tkeep}), DW'({c_prev.last, c_prev.keep}));
      end
      if (c_if.tvalid && c_if.tready) begin
        if (exp_c.size() == 0) check("ctrl_extra_beat", DW'(c_if.tvalid), 0);
        else begin
          check("ctrl_tdata", c_if.tdata, exp_c[0].data);
          check("ctrl_keep_last", DW'({c_if.tlast, c_if.tkeep}), DW'({exp_c[0].last, exp_c[0].keep}));
          void'(exp_c.pop_front());
        end
      end
      c_stall <= c_if.tvalid && !c_if.tready;
      c_prev  <= {c_if.tlast, c_if.tkeep, c_if.tdata};
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    logic [DW-1:0] hdr;
    logic [DW-1:0] b [4];
    logic [KW-1:0] k;
    longint        t0;
    int            nv;
    logic [31:0]   base_d;
    logic [31:0]   base_c;
    logic [31:0]   base_x;

    s_if.tvalid    = 1'b0;
    s_if.tdata     = '0;
    s_if.tkeep     = '0;
    s_if.tlast     = 1'b0;
    s_if.tuser_err = 1'b0;
    d_if.tready    = 1'b1;
    c_if.tready    = 1'b1;
    rand_rdy       = 0;
    cur_cls        = 0;
    exp_cnt        = '{default: 0};

    // Reset state.
    rst = 1'b1;
    repeat (2) step();
    @(negedge clk);
    check("rst_in_ready", DW'(s_if.tready), 0);
    step();
    rst = 1'b0;
    check("rst_data_valid", DW'(d_if.tvalid), 0);
    check("rst_ctrl_valid", DW'(c_if.tvalid), 0);
    check("rst_data_tlast", DW'(d_if.tlast), 0);
    check("rst_ctrl_tdata", c_if.tdata, '0);
    check("rst_data_tkeep", DW'(d_if.tkeep), 0);
    check_cnts();
    @(negedge clk);
    check("post_rst_in_ready", DW'(s_if.tready), 1);
    step();

    // Single-beat control packet, one cycle latency, bit-exact.
    hdr = mk_hdr(16'h8100, 16'h0800, 8'h11, 16'hF1F2);
    k   = rand_keep();
    send_beat(hdr, k, 1'b1, 1'b0, 1'b1);
    check("ctrl1_valid", DW'(c_if.tvalid), 1);
    check("ctrl1_tdata", c_if.tdata, hdr);
    check("ctrl1_tkeep", DW'(c_if.tkeep), DW'(k));
    check("ctrl1_data_quiet", DW'(d_if.tvalid), 0);
    drain();
    check("ctrl1_cnt", cnt_c, 1);
    check_cnts();

    // Three-beat data packet at full throughput.
    t0 = cyc;
    send_pkt(mk_hdr(16'h8100, 16'h0800, 8'h11, 16'h04D2), 3, 1'b0);
    check("data3_cycles", DW'(cyc - t0), 3);
    drain();
    check_cnts();

    // Error-flagged control-header packet is dropped without stalling.
    t0 = cyc;
    send_pkt(mk_hdr(16'h8100, 16'h0800, 8'h11, 16'hF1F2), 2, 1'b1);
    check("drop_cycles", DW'(cyc - t0), 2);
    nv = 0;
    repeat (50) begin
      @(negedge clk);
      if (d_if.tvalid || c_if.tvalid) nv++;
      step();
    end
    check("drop_no_valid", DW'(nv), 0);
    check_cnts();

    // Data backpressure: first beat held, input stalls, then all four delivered.
    d_if.tready = 1'b0;
    b[0] = mk_hdr(16'h8100, 16'h0800, 8'h11, 16'h1234);
    for (int i = 1; i < 4; i++) b[i] = rand_data();
    send_beat(b[0], '1, 1'b0, 1'b0, 1'b1);
    s_if.tdata  = b[1];
    s_if.tkeep  = '1;
    s_if.tlast  = 1'b0;
    s_if.tvalid = 1'b1;
    repeat (10) begin
      @(negedge clk);
      check("bp_in_ready", DW'(s_if.tready), 0);
      check("bp_hold_beat0", d_if.tdata, b[0]);
      step();
    end
    d_if.tready = 1'b1;
    send_beat(b[1], '1, 1'b0, 1'b0, 1'b0);
    send_beat(b[2], '1, 1'b0, 1'b0, 1'b0);
    send_beat(b[3], 64'h00FF, 1'b1, 1'b0, 1'b0);
    drain();
    check_cnts();

    // Interleaved classes under random readies.
    base_d   = cnt_d;
    base_c   = cnt_c;
    base_x   = cnt_x;
    rand_rdy = 1;
    send_pkt(mk_hdr(16'h8100, 16'h0800, 8'h11, 16'h0050), 2, 1'b0);
    send_pkt(mk_hdr(16'h8100, 16'h0800, 8'h11, 16'hF1F2), 1, 1'b0);
    send_pkt(mk_hdr(16'h8100, 16'h0800, 8'h06, 16'hF1F2), 3, 1'b0);
    send_pkt(mk_hdr(16'h8100, 16'h0800, 8'h11, 16'hF1F2), 2, 1'b0);
    drain();
    check("mix_data_delta", DW'(cnt_d - base_d), 2);
    check("mix_ctrl_delta", DW'(cnt_c - base_c), 2);
    check("mix_drop_delta", DW'(cnt_x - base_x), 0);
    check_cnts();

    // Random packet mix with near-miss headers and error flags.
    rand_rdy = 1;
    repeat (30) begin
      logic [15:0] tp;
      logic [15:0] et;
      logic [7:0]  pr;
      logic [15:0] pt;
      tp = ($urandom_range(0, 7) == 0) ? 16'h88A8 : 16'h8100;
      et = ($urandom_range(0, 7) == 0) ? 16'h86DD : 16'h0800;
      pr = ($urandom_range(0, 7) == 0) ? 8'h06 : 8'h11;
      pt = ($urandom_range(0, 1) == 0) ? 16'hF1F2 : 16'($urandom);
      send_pkt(mk_hdr(tp, et, pr, pt), $urandom_range(1, 4), 1'($urandom_range(0, 5) == 0));
    end
    drain();
    check_cnts();

    // Reset after beat 2 of a 4-beat data packet, then a clean control packet.
    send_beat(mk_hdr(16'h8100, 16'h0800, 8'h11, 16'h0007), '1, 1'b0, 1'b0, 1'b1);
    send_beat(rand_data(), '1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", DW'(s_if.tready), 0);
    step();
    rst = 1'b0;
    exp_d.delete();
    exp_c.delete();
    exp_cnt = '{default: 0};
    check("midrst_data_valid", DW'(d_if.tvalid), 0);
    check("midrst_ctrl_valid", DW'(c_if.tvalid), 0);
    check("midrst_data_tdata", d_if.tdata, '0);
    check_cnts();
    send_pkt(mk_hdr(16'h8100, 16'h0800, 8'h11, 16'hF1F2), 2, 1'b0);
    drain();
    check("midrst_ctrl_cnt", cnt_c, 1);
    check_cnts();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/pkt_ctrl_demux.md
# pkt_ctrl_demux

Per-packet classifier and router on the 512-bit H2C AXI-Stream, placed directly upstream of the Menshen packet pipeline inside the user box. It inspects the first beat of each packet and steers the whole packet to one of three destinations:
- UDP control (reconfiguration) packets go to the configuration port.
- All other well-formed packets go to the data pipeline.
- Packets flagged with `tuser_err` on their first beat are dropped.

It also keeps per-class packet counters for debug.

## Interface
Parameters:
- `C_DATA_WIDTH`, 512: AXIS data width in bits; `tkeep` is `C_DATA_WIDTH/8` bits.
- `C_CTRL_UDP_PORT`, 16'hF1F2: UDP destination port that marks a control packet.

Ports:
- `axis_aclk`  in  1  sole clock.
- `axis_rst`  in  1  reset, synchronous, active-high.
- `s_axis_tdata`  in  512  input data; byte 0 is bits [7:0].
- `s_axis_tkeep`  in  64  input byte enables.
- `s_axis_tuser_err`  in  1  error flag, sampled on the first beat only.
- `s_axis_tvalid`  in  1  input valid.
- `s_axis_tlast`  in  1  input last.
- `s_axis_tready`  out  1  input ready.
- `m_axis_data_tdata` / `_tkeep` / `_tvalid` / `_tlast`  out  512/64/1/1  data-pipeline output.
- `m_axis_data_tready`  in  1  data-pipeline ready.
- `m_axis_ctrl_tdata` / `_tkeep` / `_tvalid` / `_tlast`  out  512/64/1/1  control output.
- `m_axis_ctrl_tready`  in  1  control ready.
- `cnt_data_pkts`  out  32  count of packets forwarded to data.
- `cnt_ctrl_pkts`  out  32  count of packets forwarded to ctrl.
- `cnt_drop_pkts`  out  32  count of packets dropped.

## Operation
Header bytes examined on the first beat. Multi-byte fields are in network order, so the lower byte index is the MSB.
- Bytes 12-13: TPID, 0x8100.
- Bytes 16-17: EtherType, 0x0800.
- Byte 27: IP protocol, 0x11.
- Bytes 40-41: UDP destination port.

Classification of the first beat:
- `is_ctrl` = TPID match, EtherType match, proto match, and dst port == `C_CTRL_UDP_PORT`.
- `tuser_err`=1 takes priority: class DROP.
- Else if `is_ctrl`: class CTRL.
- Else: class DATA.

FSM states:
- IDLE: waiting for a first beat. On a first-beat handshake, go to FWD_DATA, FWD_CTRL or DROP by class. If that beat also has `tlast`, stay in IDLE.
- FWD_DATA / FWD_CTRL: pass beats to the selected output. Return to IDLE on the `tlast` handshake.
- DROP: accept and discard beats. Return to IDLE on `tlast`.
- A single-beat packet is classified and completed in the same cycle.

Output registers:
- Each output has one register stage (valid, data, keep, last).
- A register loads when a beat is routed to it and it is empty, or when it is being drained in the same cycle.

`s_axis_tready`:
- IDLE: high when both output registers can accept (empty, or draining this cycle). A new packet is never blocked on a class it does not use for more than the time that output takes to drain.
- FWD_DATA: equals the data register can-accept.
- FWD_CTRL: equals the ctrl register can-accept.
- DROP: constant 1.

Counters:
- Each counter increments by 1 on the `tlast` handshake of a packet of its class.
- 32-bit, wraps from 0xFFFFFFFF to 0.
- A data and a ctrl packet never complete in the same cycle, so counters need no arbitration.

Packet integrity: beats of one packet never appear on both outputs, and packet order within each output is preserved.

## Timing
Reset (`axis_rst`=1 at a clock edge):
- All `m_*_tvalid` = 0, `m_*_tlast` = 0, tdata/tkeep = 0.
- FSM = IDLE, all counters = 0.
- `s_axis_tready` = 0 while reset is asserted, then follows the rules above from the first cycle after reset.
- Reset mid-packet abandons the packet. Remaining beats of it arriving after reset are classified as a new first beat; this is accepted behaviour.

Latency and handshakes:
- Latency from input handshake to output valid: 1 cycle.
- Full throughput of 1 beat per cycle when the selected output is ready.
- Once asserted, `m_*_tvalid` and its payload stay stable until `m_*_tready`.
- DROP consumes 1 beat per cycle regardless of output readiness.
- Dropped packets never produce output valid.

Backpressure: holding `m_axis_data_tready` low stalls only DATA-class traffic. A CTRL packet arriving in IDLE while the data register holds an undrained beat is stalled until that register drains (IDLE readiness rule).

## Test plan
- Control packet, single beat: TPID 0x8100, EtherType 0x0800, proto 0x11, dst port 0xF1F2, `tlast`=1. Expect it on ctrl one cycle later, bit-exact, `tkeep` preserved; `cnt_ctrl_pkts`=1, data output quiet.
- Data packet: same header with dst port 0x04D2, 3 beats, all readies=1. Expect 3 consecutive beats on data with `tlast` on the third; `cnt_data_pkts`=1.
- Error drop: 2-beat control-header packet with `tuser_err`=1 on beat 1. `s_axis_tready` stays 1; neither output asserts valid for 50 cycles; `cnt_drop_pkts`=1.
- Backpressure: `m_axis_data_tready`=0 during a 4-beat data packet. The first beat is held stable on data and `s_axis_tready` goes 0. Release after 10 cycles: all 4 beats delivered in order, none lost or duplicated.
- Interleaved classes: data, ctrl, data, ctrl packets back-to-back with random readies. Each output sees only its class in order; final counts data=2, ctrl=2, drop=0.
- Reset mid-packet: assert `axis_rst` for one cycle after beat 2 of a 4-beat data packet. All valids=0 and counters=0 the next cycle; a subsequent clean ctrl packet routes correctly.
